s27_scan_seq: RTL

Scan-test sequencer that sits directly upstream of the muxed-D scan version of the s27 benchmark. It accepts test patterns over a valid/ready handshake, shifts each pattern into the three scan chains, applies primary inputs, and pulses one capture cycle. It then shifts the captured state out and compares the scan-out bits and G17 against expected values. It replaces hand-written SE/SI stimulus with a self-checking, parameterised pattern engine.

---
 rtl/s27_scan_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/s27_scan_seq.sv
// Scan-test sequencer for the muxed-D scan s27: fetches patterns over valid/ready,
// shifts them into three chains, pulses capture, unloads and scores the response.
module s27_scan_seq #(
  parameter int SHIFT_LEN = 1,
  parameter int ERR_W     = 8
) (
  input  logic                   CK,
  input  logic                   RST,
  input  logic                   START,
  input  logic                   PAT_VALID,
  output logic                   PAT_READY,
  input  logic [3*SHIFT_LEN-1:0] PAT_SCAN,
  input  logic [3:0]             PAT_PI,
  input  logic                   PAT_EXP_PO,
  input  logic [3*SHIFT_LEN-1:0] PAT_EXP_SO,
  input  logic                   PAT_LAST,
  output logic                   SE,
  output logic                   SI0,
  output logic                   SI1,
  output logic                   SI2,
  output logic                   G0,
  output logic                   G1,
  output logic                   G2,
  output logic                   G3,
  input  logic                   G17,
  input  logic                   SO0,
  input  logic                   SO1,
  input  logic                   SO2,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   FAIL,
  output logic [ERR_W-1:0]       ERR_CNT,
  output logic [ERR_W-1:0]       PAT_CNT
);
  localparam int L  = SHIFT_LEN;
  localparam int CW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SHIFT_IN, S_CAPTURE, S_SHIFT_OUT, S_FINISH
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [2:0][L-1:0]   sh_q, exp_q;
  logic [2:0]          si_q;
  logic [3:0]          g_q;
  logic                exp_po_q, last_q;
  logic                ready_q, se_q, busy_q, done_q, fail_q;
  logic [ERR_W-1:0]    err_q, pat_q;
  logic [ERR_W-1:0]    err_d, pat_d;
  logic [2:0]          mis_v;
  logic [1:0]          nmis;
  logic [ERR_W:0]      err_sum;

  logic [2:0][L-1:0]   scan_w, exso_w;
  assign scan_w = PAT_SCAN;
  assign exso_w = PAT_EXP_SO;

  wire last_cnt = (cnt_q == CW'(L - 1));

  // Bits compared this cycle: G17 in CAPTURE, the three chain MSBs in SHIFT_OUT.
  always_comb begin
    mis_v = '0;
    case (state_q)
      S_CAPTURE:   mis_v[0] = G17 ^ exp_po_q;
      S_SHIFT_OUT: mis_v = {SO2 ^ exp_q[2][L-1], SO1 ^ exp_q[1][L-1], SO0 ^ exp_q[0][L-1]};
      default:     mis_v = '0;
    endcase
    nmis    = 2'(mis_v[0]) + 2'(mis_v[1]) + 2'(mis_v[2]);
    err_sum = {1'b0, err_q} + (ERR_W+1)'(nmis);
    err_d   = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
    pat_d   = (&pat_q) ? pat_q : pat_q + ERR_W'(1);
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      exp_q    <= '0;
      si_q     <= '0;
      g_q      <= '0;
      exp_po_q <= 1'b0;
      last_q   <= 1'b0;
      ready_q  <= 1'b0;
      se_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      err_q    <= '0;
      pat_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (START) begin
          fail_q  <= 1'b0;
          err_q   <= '0;
          pat_q   <= '0;
          busy_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= S_FETCH;
        end
        S_FETCH: if (PAT_VALID && ready_q) begin
          ready_q  <= 1'b0;
          g_q      <= PAT_PI;
          exp_po_q <= PAT_EXP_PO;
          last_q   <= PAT_LAST;
          exp_q    <= exso_w;
          se_q     <= 1'b1;
          cnt_q    <= '0;
          for (int i = 0; i < 3; i++) begin
            si_q[i] <= scan_w[i][L-1];
            sh_q[i] <= scan_w[i] << 1;
          end
          state_q <= S_SHIFT_IN;
        end
        S_SHIFT_IN: begin
          if (last_cnt) begin
            se_q    <= 1'b0;
            si_q    <= '0;
            state_q <= S_CAPTURE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            for (int i = 0; i < 3; i++) begin
              si_q[i] <= sh_q[i][L-1];
              sh_q[i] <= sh_q[i] << 1;
            end
          end
        end
        S_CAPTURE: begin
          err_q   <= err_d;
          fail_q  <= fail_q | (|mis_v);
          se_q    <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_SHIFT_OUT;
        end
        S_SHIFT_OUT: begin
          err_q  <= err_d;
          fail_q <= fail_q | (|mis_v);
          for (int i = 0; i < 3; i++) exp_q[i] <= exp_q[i] << 1;
          if (last_cnt) begin
            se_q  <= 1'b0;
            pat_q <= pat_d;
            if (last_q) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_FINISH;
            end else begin
              ready_q <= 1'b1;
              state_q <= S_FETCH;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_FINISH: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign PAT_READY = ready_q;
  assign SE        = se_q;
  assign {SI2, SI1, SI0}    = si_q;
  assign {G3, G2, G1, G0}   = g_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign FAIL      = fail_q;
  assign ERR_CNT   = err_q;
  assign PAT_CNT   = pat_q;
endmodule
